// File: rtl/carry_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carry_acc_pkg
// Description : Shared types and helpers for the carry accumulator block:
//               window FSM state encoding, window-counter width helper and
//               the default-width accumulator ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package carry_acc_pkg;

    // Window-side FSM states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Accumulator ceiling for the default 16-bit build. The accumulator
    // itself detects its all-ones value directly, so other widths need no
    // entry here.
    localparam int                     ACC_WIDTH = 16;
    localparam logic [ACC_WIDTH-1:0]   ACC_MAX   = {ACC_WIDTH{1'b1}};

    // Window counter width. A WINDOW of 2 still needs one bit.
    function automatic int win_w(input int window);
        return (window > 1) ? $clog2(window) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : carry_accumulator_if
// Description : Result port of the carry accumulator. The producer (master)
//               presents a window total with a saturation flag on a
//               valid/ready handshake, plus the sticky overrun flag.
//   res_count  producer -> consumer  WIDTH  window total
//   res_sat    producer -> consumer  1      total hit the ceiling
//   res_valid  producer -> consumer  1      result available
//   res_ready  consumer -> producer  1      consumer accepts the result
//   overrun    producer -> consumer  1      a total was dropped (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
interface carry_accumulator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] res_count;
    logic             res_sat;
    logic             res_valid;
    logic             res_ready;
    logic             overrun;

    modport master (
        output res_count,
        output res_sat,
        output res_valid,
        output overrun,
        input  res_ready
    );

    modport slave (
        input  res_count,
        input  res_sat,
        input  res_valid,
        input  overrun,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/carry_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : carry_edge_det
// Description : Rising-edge detector for a counter carryout level. Each 0->1
//               transition of carry_in produces a one-cycle evt.
//   clock     in   1  posedge clock
//   carry_in  in   1  carryout level from the counter stage
//   evt       out  1  carry_in rose this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module carry_edge_det (
    input  wire logic clock,
    input  wire logic carry_in,
    output logic      evt
);

    logic r_carry_q;

    // The history flop samples carry_in on every edge, reset included, so a
    // level that is already high when reset releases is never an event. That
    // makes a reset term redundant here.
    always_ff @(posedge clock) begin
        r_carry_q <= carry_in;
    end

    assign evt = carry_in & ~r_carry_q;

endmodule
`default_nettype wire

// File: rtl/carry_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : carry_accumulator
// Description : Counts carryout rising edges over fixed windows of WINDOW
//               clock cycles and presents each saturating window total on a
//               valid/ready result port, with a sticky overrun flag.
//   clock     in   1      posedge clock
//   reset     in   1      synchronous, active-low
//   enable    in   1      1 = run windows, 0 = idle (partial window dropped)
//   carry_in  in   1      counter carryout level
//   res       master      result port (see carry_accumulator_if)
//   thresh    in   WIDTH  alarm threshold     (CARRY_ACC_THRESH_EN only)
//   alarm     out  1      result >= thresh   (CARRY_ACC_THRESH_EN only)
// Build option: define CARRY_ACC_THRESH_EN to add the thresh/alarm compare.
// Revision    : 1.0 - initial release
// ============================================================================
module carry_accumulator
    import carry_acc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 256
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             enable,
    input  wire logic             carry_in,
`ifdef CARRY_ACC_THRESH_EN
    input  wire logic [WIDTH-1:0] thresh,
    output logic                  alarm,
`endif
    carry_accumulator_if.master   res
);

    localparam int                 c_WIN_W    = win_w(WINDOW);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);

    logic               w_evt;
    state_t             r_state,   w_state_nxt;
    logic [c_WIN_W-1:0] r_win_cnt, w_win_cnt_nxt;
    logic [WIDTH-1:0]   r_acc,     w_acc_nxt;
    logic               r_sat,     w_sat_nxt;
    logic [WIDTH-1:0]   w_total;
    logic               w_total_sat;
    logic               w_win_end;
    logic               w_accept;

    logic [WIDTH-1:0]   r_res_count;
    logic               r_res_sat;
    logic               r_res_valid;
    logic               r_overrun;

    carry_edge_det u_edge_det (
        .clock    (clock),
        .carry_in (carry_in),
        .evt      (w_evt)
    );

    // ------------------------------------------------------------------
    // Window FSM and accumulator
    // ------------------------------------------------------------------
    always_comb begin
        // Running total including this cycle's event. The total sticks at
        // all-ones; sat marks that at least one event had nowhere to go.
        w_total     = r_acc;
        w_total_sat = r_sat;
        if (w_evt) begin
            if (&r_acc) begin
                w_total_sat = 1'b1;
            end else begin
                w_total = r_acc + WIDTH'(1);
            end
        end

        w_state_nxt   = r_state;
        w_win_cnt_nxt = r_win_cnt;
        w_acc_nxt     = r_acc;
        w_sat_nxt     = r_sat;
        w_win_end     = 1'b0;

        case (r_state)
            IDLE: begin
                w_win_cnt_nxt = '0;
                w_acc_nxt     = '0;
                w_sat_nxt     = 1'b0;
                if (enable) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // Dropping enable wins even on the last window cycle:
                    // an interrupted window never produces a result.
                    w_state_nxt   = IDLE;
                    w_win_cnt_nxt = '0;
                    w_acc_nxt     = '0;
                    w_sat_nxt     = 1'b0;
                end else if (r_win_cnt == c_WIN_LAST) begin
                    // Closing cycle: its event is already inside w_total,
                    // and the next window starts from zero.
                    w_win_end     = 1'b1;
                    w_win_cnt_nxt = '0;
                    w_acc_nxt     = '0;
                    w_sat_nxt     = 1'b0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + c_WIN_W'(1);
                    w_acc_nxt     = w_total;
                    w_sat_nxt     = w_total_sat;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // The result register can take a new total when it is empty or is
        // being emptied this very cycle.
        w_accept = !r_res_valid || res.res_ready;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_win_cnt <= '0;
            r_acc     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_win_cnt <= w_win_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_sat     <= w_sat_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Result register and handshake. Independent of the window FSM so a
    // pending result survives enable going low.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_res_count <= '0;
            r_res_sat   <= 1'b0;
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_win_end) begin
            if (w_accept) begin
                r_res_count <= w_total;
                r_res_sat   <= w_total_sat;
                r_res_valid <= 1'b1;
            end else begin
                // Held result stays put; the new total is lost.
                r_overrun   <= 1'b1;
            end
        end else if (r_res_valid && res.res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res.res_count = r_res_count;
    assign res.res_sat   = r_res_sat;
    assign res.res_valid = r_res_valid;
    assign res.overrun   = r_overrun;

`ifdef CARRY_ACC_THRESH_EN
    // One-cycle pulse aligned with the result register load; dropped totals
    // never reach it.
    logic r_alarm;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= w_win_end && w_accept && (w_total >= thresh);
        end
    end

    assign alarm = r_alarm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_carry_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_carry_accumulator
// Description : Self-checking bench for carry_accumulator (WIDTH=4,
//               WINDOW=32). A behavioural model counts edges per window with
//               plain integers and tracks the expected result port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_accumulator;

    localparam int W    = 4;
    localparam int WIN  = 32;
    localparam int MAXV = (1 << W) - 1;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic carry_in;
    logic ready;

    int total = 0;
    int bad   = 0;

    carry_accumulator_if #(.WIDTH(W)) res ();
    assign res.res_ready = ready;

`ifdef CARRY_ACC_THRESH_EN
    logic [W-1:0] thresh;
    logic         alarm;
`endif

    carry_accumulator #(
        .WIDTH  (W),
        .WINDOW (WIN)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .carry_in (carry_in),
`ifdef CARRY_ACC_THRESH_EN
        .thresh   (thresh),
        .alarm    (alarm),
`endif
        .res      (res)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model: windows as integer positions, totals as plain ints
    // ------------------------------------------------------------------
    logic         m_prev;
    bit           m_run;
    int           m_pos;
    int           m_cnt;
    logic         m_valid;
    logic [W-1:0] m_count;
    logic         m_sat;
    logic         m_over;
    logic         m_alarm;

    always @(posedge clock) begin : p_model
        bit ev;
        bit end_now;
        int tot;
        end_now = 1'b0;
        tot     = 0;
        ev      = (carry_in === 1'b1) && (m_prev === 1'b0);
        m_prev  = carry_in;
        if (reset === 1'b0) begin
            m_run = 1'b0; m_pos = 0; m_cnt = 0;
            m_valid = 1'b0; m_count = '0; m_sat = 1'b0; m_over = 1'b0; m_alarm = 1'b0;
        end else begin
            m_alarm = 1'b0;
            if (!m_run) begin
                if (enable) begin m_run = 1'b1; m_pos = 0; m_cnt = 0; end
            end else if (!enable) begin
                m_run = 1'b0;
            end else begin
                m_cnt = m_cnt + int'(ev);
                if (m_pos == WIN - 1) begin
                    end_now = 1'b1; tot = m_cnt; m_cnt = 0; m_pos = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            if (end_now) begin
                if (!m_valid || ready) begin
                    m_valid = 1'b1;
                    m_count = W'((tot > MAXV) ? MAXV : tot);
                    m_sat   = (tot > MAXV);
`ifdef CARRY_ACC_THRESH_EN
                    m_alarm = (m_count >= thresh);
`endif
                end else begin
                    m_over = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Inputs change right after a falling edge; outputs are read at the next
    // falling edge, one rising edge later.
    task automatic tick(input logic en, input logic c, input logic rdy);
        enable = en; carry_in = c; ready = rdy;
        @(negedge clock);
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0;
        repeat (n) tick(1'b0, 1'b0, 1'b1);
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick(1'b0, 1'b1, 1'b1);
        total++;
        if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== '0) begin
            bad++;
            $display("FAIL reset_state: got v%0b c%0d s%0b o%0b want all 0",
                     res.res_valid, res.res_count, res.res_sat, res.overrun);
        end
        reset = 1'b1;
        // carry_in stays high from reset onward: no edge, first total is 0
        for (int i = 0; i <= WIN; i++) begin
            tick(1'b1, 1'b1, 1'b1);
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL reset_model i=%0d: got v%0b c%0d s%0b o%0b want v%0b c%0d s%0b o%0b", i,
                         res.res_valid, res.res_count, res.res_sat, res.overrun, m_valid, m_count, m_sat, m_over);
            end
            total++;
            if (res.res_valid !== (i == WIN)) begin
                bad++;
                $display("FAIL reset_latency i=%0d: got valid %0b want %0b", i, res.res_valid, (i == WIN));
            end
            if (res.res_valid === 1'b1) begin
                total++;
                if ({res.res_count, res.res_sat} !== {W'(0), 1'b0}) begin
                    bad++;
                    $display("FAIL reset_level_carry: got c%0d s%0b want c0 s0", res.res_count, res.res_sat);
                end
            end
        end
    endtask

    task automatic test_periodic();
        int n = 0;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 3 * WIN; i++) begin
            tick(1'b1, (i % 4 == 0), 1'b1);
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL periodic_model i=%0d: got v%0b c%0d s%0b o%0b want v%0b c%0d s%0b o%0b", i,
                         res.res_valid, res.res_count, res.res_sat, res.overrun, m_valid, m_count, m_sat, m_over);
            end
            total++;
            if (res.res_valid !== (i > 0 && i % WIN == 0)) begin
                bad++;
                $display("FAIL periodic_timing i=%0d: got valid %0b want %0b", i, res.res_valid, (i > 0 && i % WIN == 0));
            end
            if (res.res_valid === 1'b1) begin
                n++;
                total++;
                if ({res.res_count, res.res_sat} !== {W'(8), 1'b0}) begin
                    bad++;
                    $display("FAIL periodic_total: got c%0d s%0b want c8 s0", res.res_count, res.res_sat);
                end
            end
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL periodic_count: got %0d results want 3", n);
        end
    endtask

    task automatic test_level_high();
        int n = 0;
        int exp_tot [3] = '{1, 0, 0};
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 3 * WIN; i++) begin
            tick(1'b1, (i >= 1), 1'b1);
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL level_model i=%0d: got v%0b c%0d want v%0b c%0d", i,
                         res.res_valid, res.res_count, m_valid, m_count);
            end
            if (res.res_valid === 1'b1 && n < 3) begin
                total++;
                if (res.res_count !== W'(exp_tot[n])) begin
                    bad++;
                    $display("FAIL level_total[%0d]: got %0d want %0d", n, res.res_count, exp_tot[n]);
                end
                n++;
            end
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL level_count: got %0d results want 3", n);
        end
    endtask

    task automatic test_saturate();
        logic c;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        // window 1: 16 edges (overflows a 4-bit total); window 2: 14 edges
        for (int i = 1; i <= 2 * WIN; i++) begin
            c = (i <= WIN) ? (i % 2 == 1) : (i <= 2 * WIN - 5 && i % 2 == 1);
            tick(1'b1, c, 1'b1);
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL sat_model i=%0d: got v%0b c%0d s%0b want v%0b c%0d s%0b", i,
                         res.res_valid, res.res_count, res.res_sat, m_valid, m_count, m_sat);
            end
            if (i == WIN) begin
                total++;
                if ({res.res_valid, res.res_count, res.res_sat} !== {1'b1, W'(MAXV), 1'b1}) begin
                    bad++;
                    $display("FAIL sat_full: got v%0b c%0d s%0b want v1 c%0d s1", res.res_valid, res.res_count, res.res_sat, MAXV);
                end
            end
            if (i == 2 * WIN) begin
                total++;
                if ({res.res_valid, res.res_count, res.res_sat} !== {1'b1, W'(14), 1'b0}) begin
                    bad++;
                    $display("FAIL sat_below: got v%0b c%0d s%0b want v1 c14 s0", res.res_valid, res.res_count, res.res_sat);
                end
            end
        end
    endtask

    task automatic test_boundary();
        int exp_tot [3] = '{1, 0, 1};
        int w;
        int pos;
        hold_reset(2);
        tick(1'b1, 1'b0, 1'b1);
        // edge on the last cycle of window 0 and on the first cycle of window 2
        for (int i = 1; i <= 3 * WIN; i++) begin
            w   = (i - 1) / WIN;
            pos = (i - 1) % WIN;
            tick(1'b1, (w == 0 && pos == WIN - 1) || (w == 2 && pos == 0), 1'b1);
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL boundary_model i=%0d: got v%0b c%0d want v%0b c%0d", i,
                         res.res_valid, res.res_count, m_valid, m_count);
            end
            if (i % WIN == 0) begin
                total++;
                if ({res.res_valid, res.res_count} !== {1'b1, W'(exp_tot[w])}) begin
                    bad++;
                    $display("FAIL boundary_total[%0d]: got v%0b c%0d want v1 c%0d", w, res.res_valid, res.res_count, exp_tot[w]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int   n_w [3] = '{0, 0, 0};
        logic c;
        logic c_prev;
        hold_reset(2);
        c_prev = 1'($urandom_range(0, 1));
        tick(1'b1, c_prev, 1'b0);
        for (int i = 1; i <= 3 * WIN; i++) begin
            c = 1'($urandom_range(0, 1));
            tick(1'b1, c, (i >= 2 * WIN + 5));
            if (c && !c_prev) n_w[(i - 1) / WIN]++;
            c_prev = c;
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL overrun_model i=%0d: got v%0b c%0d s%0b o%0b want v%0b c%0d s%0b o%0b", i,
                         res.res_valid, res.res_count, res.res_sat, res.overrun, m_valid, m_count, m_sat, m_over);
            end
            total++;
            if (res.overrun !== (i >= 2 * WIN)) begin
                bad++;
                $display("FAIL overrun_flag i=%0d: got %0b want %0b", i, res.overrun, (i >= 2 * WIN));
            end
            if (i >= WIN && i < 2 * WIN + 5) begin
                total++;
                if ({res.res_valid, res.res_count, res.res_sat} !==
                    {1'b1, W'((n_w[0] > MAXV) ? MAXV : n_w[0]), (n_w[0] > MAXV)}) begin
                    bad++;
                    $display("FAIL overrun_hold i=%0d: got v%0b c%0d s%0b want v1 c%0d", i,
                             res.res_valid, res.res_count, res.res_sat, (n_w[0] > MAXV) ? MAXV : n_w[0]);
                end
            end
            if (i == 2 * WIN + 5) begin
                total++;
                if (res.res_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL overrun_drain: got valid %0b want 0", res.res_valid);
                end
            end
            if (i == 3 * WIN) begin
                total++;
                if ({res.res_valid, res.res_count, res.res_sat} !==
                    {1'b1, W'((n_w[2] > MAXV) ? MAXV : n_w[2]), (n_w[2] > MAXV)}) begin
                    bad++;
                    $display("FAIL overrun_third: got v%0b c%0d s%0b want v1 c%0d", res.res_valid,
                             res.res_count, res.res_sat, (n_w[2] > MAXV) ? MAXV : n_w[2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        hold_reset(2);
        for (int i = 0; i <= WIN + 10; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        end
        total++;
        if (res.res_valid !== 1'b1 || m_valid !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pending: got valid %0b want 1", res.res_valid);
        end
        reset = 1'b0;
        tick(1'b1, 1'b0, 1'b1);
        total++;
        if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== '0) begin
            bad++;
            $display("FAIL midreset_clear: got v%0b c%0d s%0b o%0b want all 0",
                     res.res_valid, res.res_count, res.res_sat, res.overrun);
        end
        reset = 1'b1;
        for (int j = 0; j <= WIN; j++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            total++;
            if (res.res_valid !== (j == WIN)) begin
                bad++;
                $display("FAIL midreset_window j=%0d: got valid %0b want %0b", j, res.res_valid, (j == WIN));
            end
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL midreset_model j=%0d: got v%0b c%0d want v%0b c%0d", j,
                         res.res_valid, res.res_count, m_valid, m_count);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12 * WIN; i++) begin
            tick(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
            total++;
            if ({res.res_valid, res.res_count, res.res_sat, res.overrun} !== {m_valid, m_count, m_sat, m_over}) begin
                bad++;
                $display("FAIL random_model i=%0d: got v%0b c%0d s%0b o%0b want v%0b c%0d s%0b o%0b", i,
                         res.res_valid, res.res_count, res.res_sat, res.overrun, m_valid, m_count, m_sat, m_over);
            end
        end
    endtask

`ifdef CARRY_ACC_THRESH_EN
    task automatic test_thresh();
        int k [3] = '{2, 3, 5};
        int w;
        int pos;
        thresh = W'(3);
        hold_reset(2);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3 * WIN; i++) begin
            w   = (i - 1) / WIN;
            pos = (i - 1) % WIN;
            tick(1'b1, (pos < 2 * k[w]) && (pos % 2 == 0), 1'b1);
            total++;
            if (alarm !== m_alarm) begin
                bad++;
                $display("FAIL thresh_model i=%0d: got alarm %0b want %0b", i, alarm, m_alarm);
            end
            if (i % WIN == 0) begin
                total++;
                if ({res.res_valid, res.res_count, alarm} !== {1'b1, W'(k[w]), (k[w] >= 3)}) begin
                    bad++;
                    $display("FAIL thresh_result[%0d]: got v%0b c%0d a%0b want v1 c%0d a%0b", w,
                             res.res_valid, res.res_count, alarm, k[w], (k[w] >= 3));
                end
            end else begin
                total++;
                if (alarm !== 1'b0) begin
                    bad++;
                    $display("FAIL thresh_quiet i=%0d: got alarm %0b want 0", i, alarm);
                end
            end
        end
    endtask
`endif

    initial begin
        reset    = 1'b0;
        enable   = 1'b0;
        carry_in = 1'b0;
        ready    = 1'b1;
`ifdef CARRY_ACC_THRESH_EN
        thresh   = '0;
`endif
        @(negedge clock);
        test_reset();
        test_periodic();
        test_level_high();
        test_saturate();
        test_boundary();
        test_overrun();
        test_reset_mid();
        test_random();
`ifdef CARRY_ACC_THRESH_EN
        test_thresh();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
